nonce_sequencer: RTL and testbench

NONCE_SEQUENCER -- requirements
Module: nonce_sequencer

---
 rtl/nonce_sequencer.sv | 135 +++++++++++++
 tb/tb_nonce_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_sequencer.sv
// Nonce search sequencer: loads NUM_BLOCKS blocks from a registered-read memory and
// sweeps nonces through an external hash core until a result falls below target.
module nonce_sequencer #(
  parameter int                 DATA_SIZE  = 128,
  parameter int                 NONCE_W    = 32,
  parameter int                 HASH_W     = 24,
  parameter logic [NONCE_W-1:0] MAX_NONCE  = {NONCE_W{1'b1}},
  parameter int                 NUM_BLOCKS = 4
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic                         start,
  input  logic [HASH_W-1:0]            target,
  input  logic [DATA_SIZE-1:0]         block_in,
  output logic                         next,
  output logic                         hash_valid,
  input  logic                         hash_ready,
  output logic [DATA_SIZE+NONCE_W-1:0] hash_data,
  input  logic                         res_valid,
  input  logic [HASH_W-1:0]            res_hash,
  output logic                         found,
  output logic [NONCE_W-1:0]           found_nonce,
  output logic                         busy,
  output logic                         done
);

  localparam int BCNT_W = $clog2(NUM_BLOCKS + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                 state_r;
  logic                   load_cnt_r;
  logic [BCNT_W-1:0]      block_cnt_r;
  logic [DATA_SIZE-1:0]   block_reg_r;
  logic [NONCE_W-1:0]     nonce_r;

  logic                   hit_s;
  logic                   last_nonce_s;
  logic                   last_block_s;

  // Classify the current result and position within the run
  always_comb begin
    hit_s        = (res_hash < target);
    last_nonce_s = (nonce_r == MAX_NONCE);
    last_block_s = (block_cnt_r == BCNT_W'(NUM_BLOCKS - 1));
  end

  // Request payload comes straight from registers, so it is stable while stalled
  assign hash_data = {block_reg_r, nonce_r};

  // Main sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_r     <= ST_IDLE;
      load_cnt_r  <= 1'b0;
      block_cnt_r <= {BCNT_W{1'b0}};
      block_reg_r <= {DATA_SIZE{1'b0}};
      nonce_r     <= {NONCE_W{1'b0}};
      next        <= 1'b0;
      hash_valid  <= 1'b0;
      found       <= 1'b0;
      found_nonce <= {NONCE_W{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      next  <= 1'b0;
      found <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r     <= ST_LOAD;
            block_cnt_r <= {BCNT_W{1'b0}};
            load_cnt_r  <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b1;
          end
        end
        // Two cycles: one for the pointer to move, one for the registered read
        ST_LOAD: begin
          if (load_cnt_r) begin
            block_reg_r <= block_in;
            nonce_r     <= {NONCE_W{1'b0}};
            load_cnt_r  <= 1'b0;
            hash_valid  <= 1'b1;
            state_r     <= ST_ISSUE;
          end else begin
            load_cnt_r  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (hash_ready) begin
            hash_valid <= 1'b0;
            state_r    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (res_valid) begin
            if (hit_s || last_nonce_s) begin
              found       <= hit_s;
              if (hit_s) begin
                found_nonce <= nonce_r;
              end
              next        <= 1'b1;
              block_cnt_r <= block_cnt_r + BCNT_W'(1);
              if (last_block_s) begin
                state_r <= ST_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                state_r <= ST_LOAD;
              end
            end else begin
              nonce_r    <= nonce_r + NONCE_W'(1);
              hash_valid <= 1'b1;
              state_r    <= ST_ISSUE;
            end
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          hash_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_sequencer.sv
// Bench for nonce_sequencer: memory and hash-core models around a default instance
// and a MAX_NONCE=3 instance, table-driven runs plus hand-written corner sequences.
module tb_nonce_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_L = 1'b0;
  logic        start   = 1'b0;
  logic        hready  = 1'b1;
  logic        rsp_en  = 1'b1;
  logic        inj     = 1'b0;
  logic [23:0] target  = 24'h000100;
  logic [23:0] whash   = 24'hFFFFFF;
  logic [31:0] win     = 32'd99;

  logic [127:0] mem [8];

  // instance A: default parameters
  logic         next_a, hv_a, found_a, busy_a, done_a;
  logic         rv_a = 1'b0;
  logic [159:0] hd_a;
  logic [23:0]  rh_a = 24'hFFFFFF;
  logic [31:0]  fn_a;
  logic [127:0] bin_a;
  logic [2:0]   ptr_a;

  // instance B: MAX_NONCE = 3
  logic         next_b, hv_b, found_b, busy_b, done_b;
  logic         rv_b = 1'b0;
  logic [159:0] hd_b;
  logic [23:0]  rh_b = 24'hFFFFFF;
  logic [31:0]  fn_b;
  logic [127:0] bin_b;
  logic [2:0]   ptr_b;

  nonce_sequencer dut (
    .clk(clk), .reset_L(reset_L), .start(start), .target(target), .block_in(bin_a),
    .next(next_a), .hash_valid(hv_a), .hash_ready(hready), .hash_data(hd_a),
    .res_valid(rv_a), .res_hash(rh_a), .found(found_a), .found_nonce(fn_a),
    .busy(busy_a), .done(done_a)
  );

  nonce_sequencer #(.MAX_NONCE(32'd3)) dut3 (
    .clk(clk), .reset_L(reset_L), .start(start), .target(target), .block_in(bin_b),
    .next(next_b), .hash_valid(hv_b), .hash_ready(hready), .hash_data(hd_b),
    .res_valid(rv_b), .res_hash(rh_b), .found(found_b), .found_nonce(fn_b),
    .busy(busy_b), .done(done_b)
  );

  // memory models: pointer advances on next, read data registered
  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr_a <= 3'd0; bin_a <= mem[0];
    end else if (next_a) begin
      ptr_a <= ptr_a + 3'd1; bin_a <= mem[3'(ptr_a + 3'd1)];
    end else begin
      bin_a <= mem[ptr_a];
    end
  end

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr_b <= 3'd0; bin_b <= mem[0];
    end else if (next_b) begin
      ptr_b <= ptr_b + 3'd1; bin_b <= mem[3'(ptr_b + 3'd1)];
    end else begin
      bin_b <= mem[ptr_b];
    end
  end

  // hash core models: result in the cycle after acceptance
  always @(posedge clk) begin
    rv_a <= (hv_a & hready & rsp_en) | inj;
    rh_a <= (hd_a[31:0] == win) ? whash : 24'hFFFFFF;
    rv_b <= (hv_b & hready & rsp_en) | inj;
    rh_b <= (hd_b[31:0] == win) ? whash : 24'hFFFFFF;
  end

  // event monitors
  int nxt_a = 0, fnd_a = 0, acc_a = 0, nxt_b = 0, fnd_b = 0, acc_b = 0;
  logic [31:0]  accq_b[$];
  logic [127:0] blkq_a[$];
  logic [31:0]  fnq_a[$];

  always @(posedge clk) begin
    if (next_a) nxt_a <= nxt_a + 1;
    if (found_a) begin
      fnd_a <= fnd_a + 1;
      blkq_a.push_back(hd_a[159:32]);
      fnq_a.push_back(fn_a);
    end
    if (hv_a && hready) acc_a <= acc_a + 1;
    if (next_b) nxt_b <= nxt_b + 1;
    if (found_b) fnd_b <= fnd_b + 1;
    if (hv_b && hready) begin
      acc_b <= acc_b + 1;
      accq_b.push_back(hd_b[31:0]);
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_L = 1'b0; start = 1'b0; inj = 1'b0;
    repeat (2) tick();
    reset_L = 1'b1;
    tick();
  endtask

  task automatic wait_done_a(input int budget);
    for (int i = 0; i < budget && !done_a; i++) tick();
  endtask

  task automatic wait_done_b(input int budget);
    for (int i = 0; i < budget && !done_b; i++) tick();
  endtask

  typedef struct {
    logic [31:0] win;
    logic [23:0] whash;
    logic [23:0] tgt;
    int          exp_found;
    logic [31:0] exp_fn;
    int          exp_acc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int qs, n0, f0, a0, mism, idx, lastn;
    logic [159:0] hd0;

    mem[0] = 128'h397d9f2f40ca9e6c6b1f3324fded873c;
    mem[1] = 128'h11111111222222223333333344444444;
    mem[2] = 128'hA5A5A5A55A5A5A5ADEADBEEFCAFEF00D;
    mem[3] = 128'h0123456789ABCDEFFEDCBA9876543210;
    mem[4] = 128'h44444444444444444444444444444444;
    mem[5] = 128'h55555555555555555555555555555555;
    mem[6] = 128'h66666666666666666666666666666666;
    mem[7] = 128'h77777777777777777777777777777777;

    // win nonce, win hash, target, found pulses, found_nonce, accepted requests
    vecs[0] = '{32'd2, 24'h0000FF, 24'h000100, 4, 32'd2, 12};
    vecs[1] = '{32'd2, 24'h000100, 24'h000100, 0, 32'd0, 16};
    vecs[2] = '{32'd3, 24'h000000, 24'h000001, 4, 32'd3, 16};
    vecs[3] = '{32'd0, 24'h7FFFFF, 24'hFFFFFF, 4, 32'd0, 4};
    vecs[4] = '{32'd1, 24'h000000, 24'h000000, 0, 32'd0, 16};
    vecs[5] = '{32'd7, 24'h000000, 24'hFFFFFF, 0, 32'd0, 16};

    // reset values, then nothing moves after release without start
    repeat (3) tick();
    chk("reset ctl A", {next_a, hv_a, found_a, busy_a, done_a}, 160'd0);
    chk("reset data A", hd_a, 160'd0);
    chk("reset fn A", fn_a, 160'd0);
    chk("reset ctl B", {next_b, hv_b, found_b, busy_b, done_b}, 160'd0);
    reset_L = 1'b1;
    repeat (4) tick();
    chk("idle hold A", {next_a, hv_a, found_a, busy_a, done_a, fn_a}, 160'd0);
    chk("idle hold data A", hd_a, 160'd0);

    // table-driven runs on the MAX_NONCE=3 instance
    for (int v = 0; v < 6; v++) begin
      win = vecs[v].win; whash = vecs[v].whash; target = vecs[v].tgt;
      hready = 1'b1; rsp_en = 1'b1;
      do_reset();
      qs = accq_b.size(); n0 = nxt_b; f0 = fnd_b; a0 = acc_b;
      start = 1'b1; tick(); start = 1'b0;
      wait_done_b(600);
      tick();
      chk($sformatf("v%0d done", v), done_b, 160'd1);
      chk($sformatf("v%0d busy", v), busy_b, 160'd0);
      chk($sformatf("v%0d next count", v), nxt_b - n0, 160'd4);
      chk($sformatf("v%0d found count", v), fnd_b - f0, vecs[v].exp_found);
      chk($sformatf("v%0d found_nonce", v), fn_b, vecs[v].exp_fn);
      chk($sformatf("v%0d accepted", v), acc_b - a0, vecs[v].exp_acc);
      lastn = (vecs[v].exp_found > 0) ? int'(vecs[v].exp_fn) : 3;
      mism = 0; idx = qs;
      for (int b = 0; b < 4; b++) begin
        for (int n = 0; n <= lastn; n++) begin
          if (idx >= accq_b.size() || accq_b[idx] != 32'(n)) mism++;
          idx++;
        end
      end
      chk($sformatf("v%0d nonce sequence errors", v), mism, 160'd0);
    end

    // winning nonce 5 on the first block of the default instance
    win = 32'd5; whash = 24'h000000; target = 24'h000100;
    do_reset();
    n0 = nxt_a; f0 = fnd_a;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 200 && !found_a; i++) tick();
    chk("win5 found seen", found_a, 160'd1);
    chk("win5 found_nonce", fn_a, 160'd5);
    chk("win5 payload", hd_a, {mem[0], 32'd5});
    tick();
    chk("win5 found pulse width", found_a, 160'd0);
    chk("win5 found count", fnd_a - f0, 160'd1);
    chk("win5 next count", nxt_a - n0, 160'd1);

    // hash_ready stall in ISSUE
    win = 32'd99; whash = 24'hFFFFFF; hready = 1'b0;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10 && !hv_a; i++) tick();
    hd0 = hd_a;
    chk("stall first payload", hd0, {mem[0], 32'd0});
    a0 = acc_a; mism = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (hv_a !== 1'b1 || hd_a !== hd0) mism++;
    end
    chk("stall hold errors", mism, 160'd0);
    chk("stall no accept", acc_a - a0, 160'd0);
    hready = 1'b1; tick(); hready = 1'b0;
    repeat (2) tick();
    chk("stall single accept", acc_a - a0, 160'd1);
    chk("stall next request valid", hv_a, 160'd1);
    chk("stall next nonce", hd_a[31:0], 160'd1);
    hready = 1'b1;

    // four blocks each winning at nonce 0
    win = 32'd0; whash = 24'h000000; target = 24'h000100;
    do_reset();
    qs = blkq_a.size();
    start = 1'b1; tick(); start = 1'b0;
    wait_done_a(300);
    tick();
    chk("four blocks done", done_a, 160'd1);
    chk("four blocks found count", blkq_a.size() - qs, 160'd4);
    for (int b = 0; b < 4; b++) begin
      if (qs + b < blkq_a.size()) begin
        chk($sformatf("block %0d data", b), blkq_a[qs + b], mem[b]);
        chk($sformatf("block %0d found_nonce", b), fnq_a[qs + b], 160'd0);
      end
    end

    // reset while a request is outstanding, then a late result
    rsp_en = 1'b0;
    do_reset();
    a0 = acc_a;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20 && (acc_a - a0) == 0; i++) tick();
    chk("wait reached", acc_a - a0, 160'd1);
    n0 = nxt_a; f0 = fnd_a;
    reset_L = 1'b0;
    #1;
    chk("async reset ctl", {next_a, hv_a, found_a, busy_a, done_a, fn_a}, 160'd0);
    chk("async reset data", hd_a, 160'd0);
    tick(); reset_L = 1'b1;
    tick(); inj = 1'b1;
    tick(); inj = 1'b0;
    mism = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({next_a, hv_a, found_a, busy_a, done_a, fn_a} !== 37'd0 || hd_a !== 160'd0) mism++;
    end
    chk("late result ignored", mism, 160'd0);
    chk("late result no pulses", (nxt_a - n0) + (fnd_a - f0), 160'd0);
    rsp_en = 1'b1;

    // start while busy is ignored; start in DONE restarts
    do_reset();
    n0 = nxt_a; f0 = fnd_a;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    chk("busy mid-run", busy_a, 160'd1);
    start = 1'b1; tick(); start = 1'b0;
    wait_done_a(300);
    tick();
    chk("busy-start done", done_a, 160'd1);
    chk("busy-start next count", nxt_a - n0, 160'd4);
    chk("busy-start found count", fnd_a - f0, 160'd4);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart done low", done_a, 160'd0);
    chk("restart busy", busy_a, 160'd1);
    wait_done_a(300);
    chk("restart completes", done_a, 160'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
